// File: rtl/adder_disp_pkg.sv
// Shared types and constants for the adder sum BCD display block.
//   state_t      : conversion FSM states (IDLE, SHIFT, DONE)
//   bcd_nibble_t : one BCD digit
//   SEG_*        : active-high seven-segment codes {g,f,e,d,c,b,a}
//   BCD_ITER     : shift iterations for a 5-bit binary input
//   add3         : double-dabble nibble correction
package adder_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef logic [3:0] bcd_nibble_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam int BCD_ITER = 5;

  // A nibble >= 5 would overflow past 9 after the next doubling, so pre-add 3.
  function automatic bcd_nibble_t add3(input bcd_nibble_t n);
    return (n >= 4'd5) ? bcd_nibble_t'(n + 4'd3) : n;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to seven-segment decoder (active-high).
//   digit_i : BCD digit; codes above 9 decode to blank
//   seg_o   : segments {g,f,e,d,c,b,a}, bit0 = a
module seg7_decoder
  import adder_disp_pkg::*;
(
  input  bcd_nibble_t digit_i,
  output logic [6:0]  seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/adder_sum_bcd_display.sv
// Converts the 5-bit adder sum to two BCD digits with a sequential
// double-dabble engine and drives a multiplexed 2-digit 7-segment display.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_valid/o_ready: input handshake, i_sum sampled on acceptance only
//   i_sum          : unsigned sum 0..31
//   o_busy         : conversion in progress (SHIFT or DONE)
//   o_done         : one-cycle completion pulse, o_bcd updated with it
//   o_bcd          : {tens, ones} of the last completed conversion
//   o_seg, o_an    : registered segment / digit-enable outputs
// Parameters: REFRESH_DIV (clocks per digit, >=2), SEG_ACTIVE_LOW (polarity).
// Build option: LEADING_ZERO_BLANK_EN blanks the tens digit when it is zero.
module adder_sum_bcd_display
  import adder_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV    = 1000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [4:0] i_sum,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_bcd,
  output logic [6:0] o_seg,
  output logic [1:0] o_an
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [2:0]       ITER_LAST = 3'(BCD_ITER - 1);
  localparam logic [6:0]       SEG_RST   = SEG_ACTIVE_LOW ? ~SEG_0 : SEG_0;
  localparam logic [1:0]       AN_RST    = SEG_ACTIVE_LOW ? 2'b10 : 2'b01;

  // Conversion datapath: [12:9] tens, [8:5] ones, [4:0] binary being shifted out.
  state_t      state_q;
  logic [12:0] sreg_q, sreg_d, sreg_adj;
  logic [2:0]  iter_q;
  logic        done_q;
  logic [7:0]  bcd_q;

  always_comb begin
    sreg_adj = {add3(sreg_q[12:9]), add3(sreg_q[8:5]), sreg_q[4:0]};
    sreg_d   = {sreg_adj[11:0], 1'b0};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      iter_q  <= '0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            sreg_q  <= {8'h00, i_sum};
            iter_q  <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          sreg_q <= sreg_d;
          iter_q <= iter_q + 3'd1;
          if (iter_q == ITER_LAST) begin
            bcd_q   <= sreg_d[12:5];
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready = (state_q == IDLE);
  assign o_busy  = (state_q != IDLE);
  assign o_done  = done_q;
  assign o_bcd   = bcd_q;

  // Display multiplexer: sel_q = 0 shows ones, 1 shows tens.
  logic [CNT_W-1:0] refresh_q;
  logic             sel_q;
  bcd_nibble_t      digit_mux;
  logic [6:0]       seg_raw, seg_d, seg_q;
  logic [1:0]       an_d, an_q;

  always_comb begin
    digit_mux = sel_q ? bcd_q[7:4] : bcd_q[3:0];
`ifdef LEADING_ZERO_BLANK_EN
    // 4'hF is not a BCD code, so the decoder renders it blank.
    if (sel_q && (bcd_q[7:4] == 4'd0)) begin
      digit_mux = 4'hF;
    end
`endif
  end

  seg7_decoder u_dec (
    .digit_i (digit_mux),
    .seg_o   (seg_raw)
  );

  always_comb begin
    seg_d = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
    an_d  = sel_q ? 2'b10 : 2'b01;
    if (SEG_ACTIVE_LOW) begin
      an_d = ~an_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      refresh_q <= '0;
      sel_q     <= 1'b0;
      seg_q     <= SEG_RST;
      an_q      <= AN_RST;
    end else begin
      if (refresh_q == CNT_LAST) begin
        refresh_q <= '0;
        sel_q     <= ~sel_q;
      end else begin
        refresh_q <= refresh_q + 1'b1;
      end
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign o_seg = seg_q;
  assign o_an  = an_q;

endmodule
